mq_decoder: RTL



---
 rtl/mq_decoder_if.sv | 30 +++
 rtl/mq_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mq_decoder_if.sv
// Bus bundle for mq_decoder.
//   bs_*  : compressed byte stream, valid/ready (decoder is the sink)
//   cx_*  : decode request (Qe index + MPS), valid/ready
//   d_*   : decision result, one-cycle pulse, no backpressure
//   marker_seen, busy : status
// master = stream/request source, slave = decoder.
interface mq_decoder_if;
    logic [7:0] bs_data;
    logic       bs_valid;
    logic       bs_ready;
    logic       cx_valid;
    logic [5:0] cx_index;
    logic       cx_mps;
    logic       cx_ready;
    logic       d_valid;
    logic       d_bit;
    logic [5:0] d_index;
    logic       d_mps;
    logic       marker_seen;
    logic       busy;

    modport master (
        output bs_data, bs_valid, cx_valid, cx_index, cx_mps,
        input  bs_ready, cx_ready, d_valid, d_bit, d_index, d_mps, marker_seen, busy
    );
    modport slave (
        input  bs_data, bs_valid, cx_valid, cx_index, cx_mps,
        output bs_ready, cx_ready, d_valid, d_bit, d_index, d_mps, marker_seen, busy
    );
endinterface

// File: rtl/mq_decoder.sv
// MQ arithmetic decoder (JPEG2000 Tier-1). Pulls compressed bytes, handles
// 0xFF bit-stuffing and marker termination, and returns one decision plus the
// next context state per request. Context memory lives outside this block.
// Ports:
//   clk, rst_n (async active-low), flush (sync restart of INIT)
//   bus : mq_decoder_if.slave (byte stream in, requests in, decisions out)
// Build option: MQD_MARKER_FLAG_EN drives marker_seen from the sticky marker
// register; without it marker_seen is tied 0 (marker handling is unchanged).
module mq_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    mq_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_READY, S_DECIDE, S_RENORM} state_t;

    // {Qe[15:0], NMPS[5:0], NLPS[5:0], SWITCH}
    function automatic logic [28:0] qe_rom(input logic [5:0] i);
        logic [28:0] r;
        case (i)
            6'd0:  r = {16'h5601, 6'd1,  6'd1,  1'b1};
            6'd1:  r = {16'h3401, 6'd2,  6'd6,  1'b0};
            6'd2:  r = {16'h1801, 6'd3,  6'd9,  1'b0};
            6'd3:  r = {16'h0AC1, 6'd4,  6'd12, 1'b0};
            6'd4:  r = {16'h0521, 6'd5,  6'd29, 1'b0};
            6'd5:  r = {16'h0221, 6'd38, 6'd33, 1'b0};
            6'd6:  r = {16'h5601, 6'd7,  6'd6,  1'b1};
            6'd7:  r = {16'h5401, 6'd8,  6'd14, 1'b0};
            6'd8:  r = {16'h4801, 6'd9,  6'd14, 1'b0};
            6'd9:  r = {16'h3801, 6'd10, 6'd14, 1'b0};
            6'd10: r = {16'h3001, 6'd11, 6'd17, 1'b0};
            6'd11: r = {16'h2401, 6'd12, 6'd18, 1'b0};
            6'd12: r = {16'h1C01, 6'd13, 6'd20, 1'b0};
            6'd13: r = {16'h1601, 6'd29, 6'd21, 1'b0};
            6'd14: r = {16'h5601, 6'd15, 6'd14, 1'b1};
            6'd15: r = {16'h5401, 6'd16, 6'd14, 1'b0};
            6'd16: r = {16'h5101, 6'd17, 6'd15, 1'b0};
            6'd17: r = {16'h4801, 6'd18, 6'd16, 1'b0};
            6'd18: r = {16'h3801, 6'd19, 6'd17, 1'b0};
            6'd19: r = {16'h3401, 6'd20, 6'd18, 1'b0};
            6'd20: r = {16'h3001, 6'd21, 6'd19, 1'b0};
            6'd21: r = {16'h2801, 6'd22, 6'd19, 1'b0};
            6'd22: r = {16'h2401, 6'd23, 6'd20, 1'b0};
            6'd23: r = {16'h2201, 6'd24, 6'd21, 1'b0};
            6'd24: r = {16'h1C01, 6'd25, 6'd22, 1'b0};
            6'd25: r = {16'h1801, 6'd26, 6'd23, 1'b0};
            6'd26: r = {16'h1601, 6'd27, 6'd24, 1'b0};
            6'd27: r = {16'h1401, 6'd28, 6'd25, 1'b0};
            6'd28: r = {16'h1201, 6'd29, 6'd26, 1'b0};
            6'd29: r = {16'h1101, 6'd30, 6'd27, 1'b0};
            6'd30: r = {16'h0AC1, 6'd31, 6'd28, 1'b0};
            6'd31: r = {16'h09C1, 6'd32, 6'd29, 1'b0};
            6'd32: r = {16'h08A1, 6'd33, 6'd30, 1'b0};
            6'd33: r = {16'h0521, 6'd34, 6'd31, 1'b0};
            6'd34: r = {16'h0441, 6'd35, 6'd32, 1'b0};
            6'd35: r = {16'h02A1, 6'd36, 6'd33, 1'b0};
            6'd36: r = {16'h0221, 6'd37, 6'd34, 1'b0};
            6'd37: r = {16'h0141, 6'd38, 6'd35, 1'b0};
            6'd38: r = {16'h0111, 6'd39, 6'd36, 1'b0};
            6'd39: r = {16'h0085, 6'd40, 6'd37, 1'b0};
            6'd40: r = {16'h0049, 6'd41, 6'd38, 1'b0};
            6'd41: r = {16'h0025, 6'd42, 6'd39, 1'b0};
            6'd42: r = {16'h0015, 6'd43, 6'd40, 1'b0};
            6'd43: r = {16'h0009, 6'd44, 6'd41, 1'b0};
            6'd44: r = {16'h0005, 6'd45, 6'd42, 1'b0};
            6'd45: r = {16'h0001, 6'd45, 6'd43, 1'b0};
            default: r = {16'h5601, 6'd46, 6'd46, 1'b0};
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  ct_q, ct_d;
    logic [3:0]  icnt_q, icnt_d;      // INIT shift steps remaining
    logic        pff_q, pff_d;        // previous consumed byte was 0xFF
    logic        mk_q, mk_d;          // marker reached; fill with 0xFF00 from now on
    logic [5:0]  idx_q, idx_d;
    logic        mps_q, mps_d;
    logic        dv_q, dv_d, dbit_q, dbit_d, dmps_q, dmps_d;
    logic [5:0]  didx_q, didx_d;

    logic [28:0] rom;
    logic [15:0] qe, as_v;
    logic [5:0]  nmps, nlps;
    logic        sw;

    assign rom  = qe_rom(idx_q);
    assign qe   = rom[28:13];
    assign nmps = rom[12:7];
    assign nlps = rom[6:1];
    assign sw   = rom[0];
    assign as_v = a_q - qe;

    // Byte fetch merged with the shift step: when CT is empty the new byte
    // (or marker fill) is added first and the result is shifted in one cycle.
    logic        shift_st, need_byte, stuff, fill, take, shift_ok;
    logic [31:0] c_fill, c_sh;
    logic [3:0]  ct_fill;

    assign shift_st  = (state_q == S_INIT) || (state_q == S_RENORM);
    assign need_byte = (ct_q == 4'd0);
    assign stuff     = pff_q && (bus.bs_data > 8'h8F);
    // A stuffed marker byte is only trusted while bs_valid qualifies bs_data.
    assign fill      = need_byte && (mk_q || (stuff && bus.bs_valid));
    assign take      = need_byte && !mk_q && !stuff && bus.bs_valid;
    assign shift_ok  = !need_byte || fill || take;

    always_comb begin
        c_fill  = c_q;
        ct_fill = ct_q;
        if (fill) begin
            c_fill  = c_q + 32'h0000_FF00;
            ct_fill = 4'd8;
        end else if (take && pff_q) begin
            c_fill  = c_q + {15'd0, bus.bs_data, 9'd0};
            ct_fill = 4'd7;
        end else if (take) begin
            c_fill  = c_q + {16'd0, bus.bs_data, 8'd0};
            ct_fill = 4'd8;
        end
    end
    assign c_sh = c_fill << 1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        c_d     = c_q;
        ct_d    = ct_q;
        icnt_d  = icnt_q;
        pff_d   = pff_q;
        mk_d    = mk_q;
        idx_d   = idx_q;
        mps_d   = mps_q;
        dv_d    = 1'b0;
        dbit_d  = dbit_q;
        didx_d  = didx_q;
        dmps_d  = dmps_q;
        if (flush) begin
            state_d = S_INIT;
            a_d     = 16'h8000;
            c_d     = 32'd0;
            ct_d    = 4'd0;
            icnt_d  = 4'd15;
            pff_d   = 1'b0;
            mk_d    = 1'b0;
        end else begin
            case (state_q)
                S_INIT, S_RENORM: begin
                    if (shift_ok) begin
                        c_d  = c_sh;
                        ct_d = ct_fill - 4'd1;
                        if (take) pff_d = (bus.bs_data == 8'hFF);
                        if (fill) mk_d = 1'b1;
                        if (state_q == S_INIT) begin
                            icnt_d = icnt_q - 4'd1;
                            if (icnt_q == 4'd1) state_d = S_READY;
                        end else begin
                            a_d = {a_q[14:0], 1'b0};
                            if (a_q[14]) state_d = S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (bus.cx_valid) begin
                        idx_d   = (bus.cx_index > 6'd46) ? 6'd46 : bus.cx_index;
                        mps_d   = bus.cx_mps;
                        state_d = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    dv_d    = 1'b1;
                    dbit_d  = mps_q;
                    didx_d  = idx_q;
                    dmps_d  = mps_q;
                    state_d = S_RENORM;
                    if (c_q[31:16] < qe) begin
                        a_d = qe;
                        if (as_v < qe) begin
                            didx_d = nmps;
                        end else begin
                            dbit_d = ~mps_q;
                            didx_d = nlps;
                            dmps_d = mps_q ^ sw;
                        end
                    end else begin
                        c_d = {c_q[31:16] - qe, c_q[15:0]};
                        a_d = as_v;
                        if (as_v[15]) begin
                            state_d = S_READY;
                        end else if (as_v < qe) begin
                            dbit_d = ~mps_q;
                            didx_d = nlps;
                            dmps_d = mps_q ^ sw;
                        end else begin
                            didx_d = nmps;
                        end
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            a_q     <= 16'h8000;
            c_q     <= 32'd0;
            ct_q    <= 4'd0;
            icnt_q  <= 4'd15;
            pff_q   <= 1'b0;
            mk_q    <= 1'b0;
            idx_q   <= 6'd0;
            mps_q   <= 1'b0;
            dv_q    <= 1'b0;
            dbit_q  <= 1'b0;
            didx_q  <= 6'd0;
            dmps_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            c_q     <= c_d;
            ct_q    <= ct_d;
            icnt_q  <= icnt_d;
            pff_q   <= pff_d;
            mk_q    <= mk_d;
            idx_q   <= idx_d;
            mps_q   <= mps_d;
            dv_q    <= dv_d;
            dbit_q  <= dbit_d;
            didx_q  <= didx_d;
            dmps_q  <= dmps_d;
        end
    end

    // rst_n gates bs_ready so nothing is offered while reset is held.
    assign bus.bs_ready = rst_n && !flush && shift_st && need_byte && !mk_q && !stuff;
    assign bus.cx_ready = (state_q == S_READY) && !flush;
    assign bus.busy     = (state_q != S_READY);
    assign bus.d_valid  = dv_q;
    assign bus.d_bit    = dbit_q;
    assign bus.d_index  = didx_q;
    assign bus.d_mps    = dmps_q;
`ifdef MQD_MARKER_FLAG_EN
    assign bus.marker_seen = mk_q;
`else
    assign bus.marker_seen = 1'b0;
`endif
endmodule
